wb_sram_slave: RTL and testbench
================================

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base address of the memory window.
REQ-002 The module SHALL have parameter MEM_AW, default 10: log2 of the number of 32-bit words (default 1024 words, 4 KB).
REQ-003 The module SHALL have parameter LAT, default 2, legal 1..8: cycles from request acceptance to response.
REQ-004 The module SHALL have parameter MAX_OUTST, default 2, legal 1..8: maximum number of accepted but unanswered requests.
REQ-005 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-006 wb_clk_i  in  1  clock; all logic on the rising edge.
REQ-007 wb_rst_i  in  1  asynchronous active-high reset.
REQ-008 wb_cyc_i  in  1  bus cycle active.
REQ-009 wb_stb_i  in  1  request strobe.
REQ-010 wb_we_i  in  1  1 = write, 0 = read.
REQ-011 wb_adr_i  in  32  byte address.
REQ-012 wb_dat_i  in  32  write data.
REQ-013 wb_sel_i  in  4  byte lane enables; bit n covers bits [8n+7:8n].
REQ-014 wb_dat_o  out  32  read data, valid only while wb_ack_o=1 for a read.
REQ-015 wb_ack_o  out  1  one-cycle successful-completion pulse.
REQ-016 wb_err_o  out  1  one-cycle error-completion pulse.
REQ-017 wb_rty_o  out  1  tied to 0.
REQ-018 wb_stall_o  out  1  request not accepted this cycle.

Function
REQ-019 A request SHALL be accepted on a rising edge where wb_cyc_i=1, wb_stb_i=1 and wb_stall_o=0 (Wishbone B4 pipelined mode).
REQ-020 A request SHALL be in range when wb_adr_i[1:0]=0 and BASE_ADDR <= wb_adr_i < BASE_ADDR + 4*2^MEM_AW; the word index SHALL be (wb_adr_i-BASE_ADDR)>>2.
REQ-021 An accepted in-range write SHALL update, at the accepting edge, only the byte lanes selected by wb_sel_i; wb_sel_i=0 SHALL still produce an ack.
REQ-022 An accepted in-range read SHALL capture the word value after any write committed on an earlier edge, carry it through a LAT-deep pipeline, and present it on wb_dat_o.
REQ-023 Every accepted request SHALL produce exactly one response (ack for in-range, err for out-of-range or misaligned) exactly LAT cycles after acceptance; responses SHALL be in order.
REQ-024 An out-of-range or misaligned write SHALL NOT modify memory.
REQ-025 wb_ack_o and wb_err_o SHALL never be 1 in the same cycle; wb_dat_o SHALL be 0 whenever wb_ack_o=0 or the response is for a write.
REQ-026 An outstanding counter (width clog2(MAX_OUTST+1)) SHALL increment on acceptance, decrement on each response, and stay unchanged when both occur on the same edge.
REQ-027 wb_stall_o SHALL be combinational and equal (outstanding counter == MAX_OUTST).
REQ-028 With LAT <= MAX_OUTST, the block SHALL accept one request per cycle indefinitely.
REQ-029 When wb_cyc_i=0, all in-flight responses SHALL be discarded, the pipeline valid bits and counter SHALL clear on the next edge, and no ack or err SHALL be emitted for them; writes already accepted remain committed.
REQ-030 wb_stb_i=1 with wb_cyc_i=0 SHALL be ignored.

Reset
REQ-031 While wb_rst_i=1, wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_dat_o=0 and wb_stall_o=0; the pipeline and counter SHALL be cleared immediately (asynchronously).
REQ-032 Memory contents SHALL NOT be reset, and no response SHALL appear for requests in flight when reset asserts.

Verification
REQ-033 Write 32'hDEAD_BEEF to 0x10 with sel=4'hF, then read 0x10 -> ack 2 cycles after each acceptance; read returns 32'hDEAD_BEEF.
REQ-034 Write 32'h1122_3344 to 0x20 with sel=4'hF, then write 32'hAABB_CCDD with sel=4'b0101, then read -> read returns 32'h11BB_33DD.
REQ-035 Reads of 0x2 (misaligned) and 0x1000 (out of range at defaults) -> wb_err_o pulses LAT cycles after each acceptance, ack stays 0, and memory is unchanged.
REQ-036 Four back-to-back reads with LAT=4 and MAX_OUTST=2 -> stall asserts after 2 acceptances, each request accepted only as a response frees a slot, and all four acks arrive in order.
REQ-037 Write to 0x30 followed by a read of 0x30 on the next cycle -> the read returns the new data.
REQ-038 Drop wb_cyc_i, or pulse wb_rst_i, one cycle after two reads are accepted -> no ack follows, the counter is 0, and stall is 0.

Source files
------------

// File: rtl/wb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : wb_sram_slave
// Brief    : Wishbone B4 pipelined SRAM slave with fixed-latency, in-order
//            ack/err responses and a bounded number of outstanding requests.
// Revision : 1.0 - initial release
// ============================================================================
module wb_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_AW    = 10,
  parameter int          LAT       = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        wb_stall_o
);

  localparam int                 c_cnt_w = $clog2(MAX_OUTST + 1);
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_OUTST);
  localparam logic [32:0]        c_base  = {1'b0, BASE_ADDR};
  localparam logic [32:0]        c_span  = 33'(4) << MEM_AW;
  localparam int                 c_words = 1 << MEM_AW;

  logic [32:0]        offset;
  logic               in_range;
  logic               accept;
  logic               resp_gen;
  logic [MEM_AW-1:0]  word_idx;

  logic [31:0]        mem_q [c_words];

  logic [LAT-1:0]     vld_d, vld_q;
  logic [LAT-1:0]     err_d, err_q;
  logic [31:0]        dat_d [LAT];
  logic [31:0]        dat_q [LAT];
  logic [c_cnt_w-1:0] cnt_d, cnt_q;

  // A borrow out of the 33-bit subtraction means the address is below the window.
  always_comb begin
    offset     = {1'b0, wb_adr_i} - c_base;
    in_range   = (wb_adr_i[1:0] == 2'b00) && !offset[32] && (offset < c_span);
    word_idx   = offset[MEM_AW+1:2];
    wb_stall_o = (cnt_q == c_max);
    accept     = wb_cyc_i && wb_stb_i && !wb_stall_o && !wb_rst_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (accept && in_range && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 captures the response; later stages only shift. Dropping cyc flushes all.
  always_comb begin
    vld_d = '0;
    err_d = '0;
    for (int i = 0; i < LAT; i++) begin
      dat_d[i] = 32'h0;
    end
    if (wb_cyc_i) begin
      vld_d[0] = accept;
      err_d[0] = accept && !in_range;
      dat_d[0] = (accept && in_range && !wb_we_i) ? mem_q[word_idx] : 32'h0;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  // A slot is released on the edge that loads a request into the response stage,
  // so LAT <= MAX_OUTST sustains one acceptance per cycle.
  generate
    if (LAT == 1) begin : g_lat_one
      assign resp_gen = accept;
    end else begin : g_lat_multi
      assign resp_gen = vld_q[LAT-2];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (!wb_cyc_i) begin
      cnt_d = '0;
    end else if (accept && !resp_gen) begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end else if (!accept && resp_gen) begin
      cnt_d = cnt_q - c_cnt_w'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      vld_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat_q[i] <= 32'h0;
      end
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LAT; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  always_comb begin
    wb_ack_o = wb_cyc_i && vld_q[LAT-1] && !err_q[LAT-1];
    wb_err_o = wb_cyc_i && vld_q[LAT-1] && err_q[LAT-1];
    wb_dat_o = wb_ack_o ? dat_q[LAT-1] : 32'h0;
    wb_rty_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sram_slave
// Brief    : Directed vector table plus pipelined, stall and abort sequences
//            against a default instance and a LAT=4/MAX_OUTST=2 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sram_slave;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
  } vec_t;

  localparam int NV = 19;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_cyc, a_stb, a_we, a_ack, a_err, a_rty, a_stall;
  logic [31:0] a_adr, a_dat_i, a_dat_o;
  logic [3:0]  a_sel;
  logic        b_cyc, b_stb, b_we, b_ack, b_err, b_rty, b_stall;
  logic [31:0] b_adr, b_dat_i, b_dat_o;
  logic [3:0]  b_sel;

  int n_vec = 0;
  int n_bad = 0;

  vec_t        vecs [NV];
  logic [31:0] b_vals [4];
  logic [31:0] a_stream_adr [6];
  logic [31:0] a_stream_dat [6];

  wb_sram_slave dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb),
    .wb_we_i(a_we), .wb_adr_i(a_adr), .wb_dat_i(a_dat_i), .wb_sel_i(a_sel),
    .wb_dat_o(a_dat_o), .wb_ack_o(a_ack), .wb_err_o(a_err), .wb_rty_o(a_rty),
    .wb_stall_o(a_stall)
  );

  wb_sram_slave #(.LAT(4), .MAX_OUTST(2)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb),
    .wb_we_i(b_we), .wb_adr_i(b_adr), .wb_dat_i(b_dat_i), .wb_sel_i(b_sel),
    .wb_dat_o(b_dat_o), .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_rty_o(b_rty),
    .wb_stall_o(b_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic rd_ack(input bit on_b);
    return on_b ? b_ack : a_ack;
  endfunction

  function automatic logic rd_err(input bit on_b);
    return on_b ? b_err : a_err;
  endfunction

  function automatic logic rd_stall(input bit on_b);
    return on_b ? b_stall : a_stall;
  endfunction

  function automatic logic [31:0] rd_dat(input bit on_b);
    return on_b ? b_dat_o : a_dat_o;
  endfunction

  task automatic drive(input bit on_b, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (on_b) begin
      b_stb = stb; b_we = we; b_adr = adr; b_dat_i = dat; b_sel = sel;
    end else begin
      a_stb = stb; a_we = we; a_adr = adr; a_dat_i = dat; a_sel = sel;
    end
  endtask

  task automatic set_cyc(input bit on_b, input logic v);
    if (on_b) b_cyc = v;
    else      a_cyc = v;
  endtask

  // Single request on an idle bus; measures latency in cycles from the accepting edge.
  task automatic xfer(input bit on_b, input vec_t v, input int exp_lat, input string tag);
    logic        got_ack, got_err;
    logic [31:0] got_dat;
    int          lat;
    got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0; lat = -1;
    @(negedge clk);
    drive(on_b, 1'b1, v.we, v.adr, v.dat, v.sel);
    @(negedge clk);
    drive(on_b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      if (rd_ack(on_b) || rd_err(on_b)) begin
        got_ack = rd_ack(on_b);
        got_err = rd_err(on_b);
        got_dat = rd_dat(on_b);
        lat     = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_ack"}, 32'(got_ack), 32'(v.ack));
    check({tag, "_err"}, 32'(got_err), 32'(v.err));
    check({tag, "_dat"}, got_dat, v.rdat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_single"}, 32'(rd_ack(on_b) | rd_err(on_b)), 32'h0);
  endtask

  // Two reads accepted back to back, then the cycle is aborted by cyc drop or reset.
  task automatic abort_test(input bit on_b, input bit use_rst, input logic [31:0] adr,
                            input logic [31:0] exp_dat, input int exp_lat, input string tag);
    int   n_resp;
    vec_t v;
    n_resp = 0;
    @(negedge clk);
    drive(on_b, 1'b1, 1'b0, adr, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_pre_stall"}, 32'(rd_stall(on_b)), 32'(on_b));
    drive(on_b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (use_rst) rst = 1'b1;
    else         set_cyc(on_b, 1'b0);
    #1;
    if (use_rst) begin
      check({tag, "_rst_ack"}, 32'(rd_ack(on_b)), 32'h0);
      check({tag, "_rst_stall"}, 32'(rd_stall(on_b)), 32'h0);
    end
    for (int k = 0; k < 6; k++) begin
      if (rd_ack(on_b) || rd_err(on_b)) n_resp++;
      if (k == 1) begin
        check({tag, "_stall"}, 32'(rd_stall(on_b)), 32'h0);
        rst = 1'b0;
      end
      @(negedge clk);
    end
    set_cyc(on_b, 1'b1);
    check({tag, "_no_resp"}, 32'(n_resp), 32'h0);
    v = '{1'b0, adr, 32'h0, 4'hF, 1'b1, 1'b0, exp_dat};
    xfer(on_b, v, exp_lat, {tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_t [4];
    int ack_t [4];
    logic [31:0] ack_d [4];
    int ni, na, n_resp;

    rst = 1'b1;
    a_cyc = 1'b0; b_cyc = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b1, 1'b0, 32'h11BB_33DD};
    vecs[6]  = '{1'b0, 32'h0000_0002, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0002, 32'h8765_4321, 4'hF, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[13] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0BAD_CAFE};
    vecs[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
    vecs[16] = '{1'b1, 32'h0000_0024, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 4'h8, 1'b1, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 32'h0000_0024, 32'h0,         4'hF, 1'b1, 1'b0, 32'hA500_0000};

    b_vals[0] = 32'h1111_0000; b_vals[1] = 32'h2222_0001;
    b_vals[2] = 32'h3333_0002; b_vals[3] = 32'h4444_0003;

    a_stream_adr[0] = 32'h0;   a_stream_dat[0] = 32'hCAFE_F00D;
    a_stream_adr[1] = 32'h10;  a_stream_dat[1] = 32'hDEAD_BEEF;
    a_stream_adr[2] = 32'h20;  a_stream_dat[2] = 32'h11BB_33DD;
    a_stream_adr[3] = 32'h24;  a_stream_dat[3] = 32'hA500_0000;
    a_stream_adr[4] = 32'h30;  a_stream_dat[4] = 32'h5A5A_1234;
    a_stream_adr[5] = 32'hFFC; a_stream_dat[5] = 32'h0BAD_CAFE;

    repeat (3) @(negedge clk);
    a_cyc = 1'b1; a_stb = 1'b1;
    #1;
    check("rst_a_ack",   32'(a_ack),   32'h0);
    check("rst_a_err",   32'(a_err),   32'h0);
    check("rst_a_rty",   32'(a_rty),   32'h0);
    check("rst_a_dat",   a_dat_o,      32'h0);
    check("rst_a_stall", 32'(a_stall), 32'h0);
    check("rst_b_stall", 32'(b_stall), 32'h0);
    check("rst_b_ack",   32'(b_ack),   32'h0);
    a_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    b_cyc = 1'b1;

    for (int i = 0; i < NV; i++) begin
      xfer(1'b0, vecs[i], 2, $sformatf("v%0d", i));
    end

    // Write then read of the same word on consecutive cycles.
    @(negedge clk);
    check("b2b_stall0", 32'(a_stall), 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h5A5A_1234, 4'hF);
    @(negedge clk);
    check("b2b_stall1", 32'(a_stall), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("b2b_wr_ack", 32'(a_ack), 32'h1);
    check("b2b_wr_dat", a_dat_o,    32'h0);
    @(negedge clk);
    check("b2b_rd_ack", 32'(a_ack), 32'h1);
    check("b2b_rd_dat", a_dat_o,    32'h5A5A_1234);
    @(negedge clk);
    check("b2b_idle", 32'(a_ack | a_err), 32'h0);

    // Full-rate read stream on the default instance never stalls.
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        check($sformatf("strm%0d_ack", t-2), 32'(a_ack), 32'h1);
        check($sformatf("strm%0d_dat", t-2), a_dat_o, a_stream_dat[t-2]);
      end
      if (t < 6) begin
        check($sformatf("strm%0d_stall", t), 32'(a_stall), 32'h0);
        drive(1'b0, 1'b1, 1'b0, a_stream_adr[t], 32'h0, 4'hF);
      end else begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    @(negedge clk);
    check("strm_idle", 32'(a_ack | a_err), 32'h0);

    // A strobe without cyc must not be accepted.
    a_cyc = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
    n_resp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_ack || a_err) n_resp++;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    a_cyc = 1'b1;
    check("nocyc_resp", 32'(n_resp), 32'h0);
    xfer(1'b0, '{1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFE_F00D}, 2, "nocyc_rd");

    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, '{1'b1, 32'h100 + 32'(4*i), b_vals[i], 4'hF, 1'b1, 1'b0, 32'h0}, 4,
           $sformatf("bpre%0d", i));
    end

    // LAT=4, MAX_OUTST=2: accepts at cycles 0,1,4,5 and acks at 4,5,8,9.
    ni = 0; na = 0;
    for (int i = 0; i < 4; i++) begin
      acc_t[i] = -1; ack_t[i] = -1; ack_d[i] = 32'h0;
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (b_ack) begin
        if (na < 4) begin
          ack_t[na] = t;
          ack_d[na] = b_dat_o;
        end
        na++;
      end
      if (ni < 4) begin
        drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4*ni), 32'h0, 4'hF);
        if (!b_stall) begin
          acc_t[ni] = t;
          ni++;
        end
      end else begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    check("bstrm_nack", 32'(na), 32'h4);
    check("bstrm_acc0", 32'(acc_t[0]), 32'h0);
    check("bstrm_acc1", 32'(acc_t[1]), 32'h1);
    check("bstrm_acc2", 32'(acc_t[2]), 32'h4);
    check("bstrm_acc3", 32'(acc_t[3]), 32'h5);
    check("bstrm_ack0", 32'(ack_t[0]), 32'h4);
    check("bstrm_ack1", 32'(ack_t[1]), 32'h5);
    check("bstrm_ack2", 32'(ack_t[2]), 32'h8);
    check("bstrm_ack3", 32'(ack_t[3]), 32'h9);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bstrm_dat%0d", i), ack_d[i], b_vals[i]);
    end

    abort_test(1'b0, 1'b0, 32'h10,  32'hDEAD_BEEF, 2, "a_cycdrop");
    abort_test(1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 2, "a_rst");
    abort_test(1'b1, 1'b0, 32'h104, b_vals[1],     4, "b_cycdrop");
    abort_test(1'b1, 1'b1, 32'h108, b_vals[2],     4, "b_rst");

    check("end_a_rty", 32'(a_rty), 32'h0);
    check("end_b_rty", 32'(b_rty), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
